// File: rtl/handshake_pkg.sv
// Shared handshake fabric helpers: width functions, channel defaults and
// the transfer-kind encoding used by elastic stages.
package handshake_pkg;

  localparam int unsigned HS_DATA_WIDTH = 32;
  localparam int unsigned HS_DEPTH      = 4;
  localparam int unsigned HS_MAX_DEPTH  = 64;

  // {push, pop} as seen at a single clock edge
  typedef enum logic [1:0] {
    XFER_IDLE = 2'b00,
    XFER_POP  = 2'b01,
    XFER_PUSH = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Pointer width never drops below one bit, even for a single slot
  function automatic int unsigned PTR_W(input int unsigned depth);
    return (clog2(depth) == 0) ? 1 : clog2(depth);
  endfunction

  function automatic int unsigned CNT_W(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/handshake_wrap_counter.sv
// Modulo-MAX index counter; wraps MAX-1 -> 0 by explicit compare so
// non-power-of-two ranges work.
module handshake_wrap_counter
  import handshake_pkg::*;
#(
  parameter int unsigned MAX = 4,
  localparam int unsigned W  = PTR_W(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc) begin
      value_d = (value_q == W'(MAX - 1)) ? '0 : value_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value_q <= '0;
    else      value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/handshake_elastic_fifo.sv
// Elastic FIFO for the handshake fabric: DEPTH slots of slack, valid/ready
// driven only from registered state so both timing directions are cut.
module handshake_elastic_fifo
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = HS_DATA_WIDTH,
  parameter int unsigned DEPTH      = HS_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int unsigned PW = PTR_W(DEPTH);
  localparam int unsigned CW = CNT_W(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_d;
  logic                  in_rdy_q, in_rdy_d;
  logic                  out_vld_q, out_vld_d;
  logic                  push, pop;
  xfer_e                 xfer;

  assign push = ins_valid & in_rdy_q;
  assign pop  = out_vld_q & outs_ready;
  assign xfer = xfer_e'({push, pop});

  handshake_wrap_counter #(.MAX(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (push),
    .value (wr_ptr)
  );

  handshake_wrap_counter #(.MAX(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (pop),
    .value (rd_ptr)
  );

  // Occupancy and the full/empty flags it implies for the next cycle
  always_comb begin
    count_d = count_q;
    unique case (xfer)
      XFER_PUSH: count_d = count_q + CW'(1);
      XFER_POP:  count_d = count_q - CW'(1);
      default:   count_d = count_q;
    endcase
    in_rdy_d  = (count_d != CW'(DEPTH));
    out_vld_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr] <= ins;
    end
  end

  assign ins_ready  = in_rdy_q;
  assign outs_valid = out_vld_q;
  assign outs       = mem_q[rd_ptr];

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Scoreboard bench for handshake_elastic_fifo: a DEPTH=4 and a DEPTH=3
// instance, both 17 bits wide, checked against a queue model every cycle.
module tb_handshake_elastic_fifo;

  localparam int unsigned DW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] ins4, outs4, ins3, outs3;
  logic          iv4, ir4, ov4, or4;
  logic          iv3, ir3, ov3, or3;

  logic [DW-1:0] q4[$];
  logic [DW-1:0] q3[$];
  int            n_total = 0;
  int            n_bad   = 0;
  int            pops4   = 0;
  int            pops3   = 0;

  always #5 clk = ~clk;

  handshake_elastic_fifo #(.DATA_WIDTH(DW), .DEPTH(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins4),
    .ins_valid  (iv4),
    .ins_ready  (ir4),
    .outs       (outs4),
    .outs_valid (ov4),
    .outs_ready (or4)
  );

  handshake_elastic_fifo #(.DATA_WIDTH(DW), .DEPTH(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins3),
    .ins_valid  (iv3),
    .ins_ready  (ir3),
    .outs       (outs3),
    .outs_valid (ov3),
    .outs_ready (or3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // One clock: check flags against the model, score transfers, then advance
  task automatic step();
    logic          p4, o4, p3, o3, hold4;
    logic [DW-1:0] h4;
    #1;
    chk("ready4", 32'(ir4), 32'(q4.size() != 4));
    chk("valid4", 32'(ov4), 32'(q4.size() != 0));
    chk("ready3", 32'(ir3), 32'(q3.size() != 3));
    chk("valid3", 32'(ov3), 32'(q3.size() != 0));
    p4 = iv4 && (q4.size() < 4);
    o4 = or4 && (q4.size() != 0);
    p3 = iv3 && (q3.size() < 3);
    o3 = or3 && (q3.size() != 0);
    if (o4) begin
      chk("pop4_data", 32'(outs4), 32'(q4.pop_front()));
      pops4++;
    end
    if (o3) begin
      chk("pop3_data", 32'(outs3), 32'(q3.pop_front()));
      pops3++;
    end
    if (p4) q4.push_back(ins4);
    if (p3) q3.push_back(ins3);
    hold4 = ov4 && !or4;
    h4    = outs4;
    @(posedge clk);
    #1;
    if (hold4) begin
      chk("hold4_valid", 32'(ov4), 32'd1);
      chk("hold4_data", 32'(outs4), 32'(h4));
    end
  endtask

  task automatic drain4();
    iv4 = 1'b0;
    or4 = 1'b1;
    for (int k = 0; k < 20 && q4.size() != 0; k++) step();
    chk("drain4", 32'(q4.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            sent;
    logic          acc;
    logic [DW-1:0] cur;

    rst = 1'b0;
    ins4 = '0; iv4 = 1'b0; or4 = 1'b0;
    ins3 = '0; iv3 = 1'b0; or3 = 1'b0;
    #12;
    chk("rst_valid", 32'(ov4), 32'd0);
    chk("rst_ready", 32'(ir4), 32'd1);
    chk("rst_outs", 32'(outs4), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-stream discards stored words without a clock edge
    for (int i = 0; i < 3; i++) begin
      ins4 = DW'(32'hAAA + 32'(i));
      iv4  = 1'b1;
      step();
    end
    iv4 = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov4), 32'd0);
    chk("midrst_ready", 32'(ir4), 32'd1);
    chk("midrst_outs", 32'(outs4), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    q4.delete();
    q3.delete();

    // Single-word latency: visible exactly one cycle after the push edge
    ins4 = DW'(32'h1E4B1);
    iv4  = 1'b1;
    or4  = 1'b1;
    step();
    iv4 = 1'b0;
    chk("lat_valid", 32'(ov4), 32'd1);
    chk("lat_outs", 32'(outs4), 32'h1E4B1);
    step();
    chk("lat_gone", 32'(ov4), 32'd0);
    chk("lat_pops", 32'(pops4), 32'd1);

    // Fill with consumer stalled; word 5 must wait upstream
    or4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      ins4 = DW'(k);
      iv4  = 1'b1;
      step();
    end
    chk("full_ready", 32'(ir4), 32'd0);
    ins4 = DW'(5);
    step();
    step();
    chk("stall_head", 32'(outs4), 32'd1);
    chk("stall_ready", 32'(ir4), 32'd0);

    // Full with valid and ready together: one pop, no push
    or4 = 1'b1;
    step();
    chk("fullpop_ready", 32'(ir4), 32'd1);
    chk("fullpop_head", 32'(outs4), 32'd2);
    chk("fullpop_occ", 32'(q4.size()), 32'd3);
    step();
    drain4();
    chk("fill_pops", 32'(pops4), 32'd6);

    // Streaming through DEPTH=3: wraps the pointers several times
    or3 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ins3 = DW'(i);
      iv3  = 1'b1;
      step();
      chk("stream_rate", 32'(pops3), 32'(i));
    end
    iv3 = 1'b0;
    step();
    chk("stream_total", 32'(pops3), 32'd10);
    chk("stream_empty", 32'(ov3), 32'd0);

    // Random valid/ready at 50% with upstream holding data until accepted
    pops4 = 0;
    sent  = 0;
    cur   = DW'($urandom);
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      iv4  = ($urandom % 2) == 1;
      or4  = ($urandom % 2) == 1;
      ins4 = cur;
      acc  = iv4 && (q4.size() < 4);
      step();
      if (acc) begin
        sent++;
        cur = DW'($urandom);
      end
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    drain4();
    chk("rand_pops", 32'(pops4), 32'd1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/handshake_elastic_fifo.md
Name: handshake_elastic_fifo

Overview:
- Elastic FIFO buffer for the handshake dataflow fabric.
- Sits directly downstream of constant/operator stages: consumes their outs/outs_valid/outs_ready channel and re-presents it to the next consumer.
- Breaks the data and valid timing paths (registered output) and the ready path (ins_ready depends only on internal state).
- Provides DEPTH slots of slack so a constant source can keep producing while the consumer stalls.

Parameters:
- DATA_WIDTH, 32, width of the ins/outs data channel.
- DEPTH, 4, number of storage slots; legal range 1..64; non-power-of-two legal.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion synchronous to clk by the system.
- ins  input  DATA_WIDTH  upstream data.
- ins_valid  input  1  upstream valid.
- ins_ready  output  1  FIFO can accept this cycle.
- outs  output  DATA_WIDTH  head-of-FIFO data.
- outs_valid  output  1  head entry present.
- outs_ready  input  1  downstream accepts.

Behaviour:
- Transfers:
  - push = ins_valid & ins_ready.
  - pop = outs_valid & outs_ready.
  - Both evaluated at the same clock edge.
- State:
  - storage array mem[DEPTH].
  - wr_ptr and rd_ptr, each clog2(DEPTH) bits; minimum 1 bit.
  - count, clog2(DEPTH+1) bits.
- Reset (rst=0, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0, all mem entries cleared to 0.
  - outs=0, outs_valid=0, ins_ready=1.
  - Reset asserted mid-operation discards all stored entries immediately, without waiting for a clock edge.
- Output signals:
  - ins_ready = (count != DEPTH). Function of registered state only; no combinational path from outs_ready.
  - outs_valid = (count != 0). outs = mem[rd_ptr].
  - No combinational path from ins/ins_valid to outs/outs_valid.
- Latency: a word pushed into an empty FIFO appears on outs/outs_valid one cycle after the push edge. There is no bypass.
- Push: mem[wr_ptr] <= ins; wr_ptr advances.
- Pop: rd_ptr advances.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. Explicit compare; never rely on power-of-two overflow.
- count update: +1 on push only, -1 on pop only, unchanged on push & pop, unchanged when idle.
- Boundary cases:
  - Full (count=DEPTH): ins_ready=0, so no push occurs even if outs_ready=1 in the same cycle. A pop frees a slot; ins_ready rises the next cycle. Full throughput requires DEPTH>=2.
  - Empty: outs_valid=0; outs holds mem[rd_ptr], which is stale and must be ignored by the consumer.
  - Simultaneous push & pop when count=1: the head is popped and the new word becomes the head the next cycle; outs_valid stays 1.
  - DEPTH=1: alternates accept/emit; throughput is 1 word per 2 cycles.
- Data ordering: strict FIFO. No word is dropped or duplicated.
- Stability: while outs_valid=1 and outs_ready=0, outs and outs_valid hold stable.
- Protocol: ins_valid must not depend combinationally on ins_ready (upstream rule). This block complies by deriving outs_valid from state only.

Decomposition:
- Shared package handshake_pkg:
  - clog2 function.
  - PTR_W(DEPTH) and CNT_W(DEPTH) width helpers.
  - Common handshake channel constants.
- One natural sub-module: handshake_wrap_counter (parameter MAX; inputs clk, rst, inc; output value). It wraps from MAX-1 to 0, and is instantiated twice, for wr_ptr and rd_ptr.
- Storage and count logic stay in the top module.

Test Plan:
- Reset mid-stream:
  - Stimulus: push 3 words, then assert rst=0 between clock edges.
  - Required: immediately outs_valid=0, ins_ready=1, outs=0.
  - After release: the first new push 0x1E4B1 is the first word popped.
- Latency, DATA_WIDTH=17, DEPTH=4:
  - Stimulus: ins=0x1E4B1, ins_valid=1 for 1 cycle, outs_ready=1.
  - Required: outs_valid=1 with outs=0x1E4B1 exactly 1 cycle later, for exactly 1 cycle.
- Fill and stall, DEPTH=4:
  - Stimulus: outs_ready=0, push 1,2,3,4,5.
  - Required: ins_ready drops to 0 after the 4th push; word 5 is held upstream.
  - Then outs_ready=1: pops 1,2,3,4 in order, then 5.
- Full with simultaneous valid/ready:
  - Stimulus: FIFO full, ins_valid=1, outs_ready=1.
  - Required: exactly one pop and no push that cycle; ins_ready=1 the next cycle.
- Streaming and wrap, DEPTH=3:
  - Stimulus: 10 consecutive words 0..9 with outs_ready=1 throughout.
  - Required: one word per cycle after a 1-cycle fill; pointers wrap 2->0 correctly; output sequence 0..9 unchanged.
- Random backpressure:
  - Stimulus: 1000 words with random ins_valid/outs_ready at 50%.
  - Required: scoreboard shows in-order, lossless delivery; outs stable whenever outs_valid & !outs_ready.
